// File: rtl/router_fsm_pkg.sv
// Shared types and constants for the 1x3 router packet-sequencing controller.
package router_fsm_pkg;

  // Controller states. The 3-bit encoding is shared with the register block and synchronizer.
  typedef enum logic [2:0] {
    StDecodeAddress    = 3'd0,
    StLoadFirstData    = 3'd1,
    StLoadData         = 3'd2,
    StFifoFullState    = 3'd3,
    StLoadAfterFull    = 3'd4,
    StLoadParity       = 3'd5,
    StCheckParityError = 3'd6,
    StWaitTillEmpty    = 3'd7
  } state_e;

  localparam logic [1:0] Port0       = 2'd0;
  localparam logic [1:0] Port1       = 2'd1;
  localparam logic [1:0] Port2       = 2'd2;
  localparam logic [1:0] AddrInvalid = 2'b11;

  // Pick the per-port flag for a port address. The invalid address selects nothing.
  function automatic logic port_sel(input logic [2:0] flags, input logic [1:0] addr);
    logic sel;
    case (addr)
      Port0:   sel = flags[0];
      Port1:   sel = flags[1];
      Port2:   sel = flags[2];
      default: sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Dwell counter for the router controller's waiting states; flags the last allowed cycle.
module router_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned CntW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count while the controller stays put in a waiting state, otherwise restart from zero.
  always_comb begin
    cnt_d = run_i ? cnt_q + 1'b1 : '0;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CntW'(WAIT_LIMIT - 1));

endmodule

// File: rtl/router_fsm.sv
// Packet-sequencing controller of the 1x3 router: decodes the header address, waits for the
// destination FIFO, and drives load strobes with FIFO-full back-pressure and parity handling.
// Optional abort of long waits is enabled by defining ROUTER_FSM_TIMEOUT_EN.
module router_fsm
  import router_fsm_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] d_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       sft_rst_0,
  input  logic       sft_rst_1,
  input  logic       sft_rst_2,
  output logic       detect_addr,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       wr_en_reg,
  output logic       busy,
  output logic       timeout_err
);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic       timeout_err_q, timeout_err_d;

  logic [2:0] empty_vec;
  logic [2:0] sft_vec;
  logic       in_wait;
  logic       sft_hit;
  logic       expire;

  assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign sft_vec   = {sft_rst_2, sft_rst_1, sft_rst_0};
  assign in_wait   = (state_q == StFifoFullState) || (state_q == StWaitTillEmpty);
  // Only the port currently being served can kick the controller back to decode.
  assign sft_hit   = (state_q != StDecodeAddress) && port_sel(sft_vec, addr_q);

`ifdef ROUTER_FSM_TIMEOUT_EN
  logic timer_expire;

  // Run only while the state is held, so entry and exit both restart the count.
  router_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .run_i    (in_wait && (state_d == state_q)),
    .expire_o (timer_expire)
  );

  assign expire = in_wait && timer_expire;
`else
  assign expire = 1'b0;
`endif

  // Next-state, address capture and abort pulse.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    timeout_err_d = 1'b0;

    if ((state_q == StDecodeAddress) && pkt_valid && (d_in != AddrInvalid)) begin
      addr_d = d_in;
    end

    if (sft_hit) begin
      state_d = StDecodeAddress;
    end else if (expire) begin
      state_d       = StDecodeAddress;
      timeout_err_d = 1'b1;
    end else begin
      unique case (state_q)
        StDecodeAddress: begin
          if (pkt_valid && (d_in != AddrInvalid)) begin
            state_d = port_sel(empty_vec, d_in) ? StLoadFirstData : StWaitTillEmpty;
          end
        end
        StLoadFirstData: state_d = StLoadData;
        StLoadData: begin
          if (fifo_full)       state_d = StFifoFullState;
          else if (!pkt_valid) state_d = StLoadParity;
        end
        StFifoFullState: begin
          if (!fifo_full) state_d = StLoadAfterFull;
        end
        StLoadAfterFull: begin
          if (parity_done)        state_d = StDecodeAddress;
          else if (low_pkt_valid) state_d = StLoadParity;
          else                    state_d = StLoadData;
        end
        StLoadParity: state_d = StCheckParityError;
        StCheckParityError: begin
          state_d = fifo_full ? StFifoFullState : StDecodeAddress;
        end
        StWaitTillEmpty: begin
          if (port_sel(empty_vec, addr_q)) state_d = StLoadFirstData;
        end
        default: state_d = StDecodeAddress;
      endcase
    end
  end

  // State, captured address and abort flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StDecodeAddress;
      addr_q        <= Port0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    detect_addr = (state_q == StDecodeAddress);
    lfd_state   = (state_q == StLoadFirstData);
    ld_state    = (state_q == StLoadData);
    laf_state   = (state_q == StLoadAfterFull);
    full_state  = (state_q == StFifoFullState);
    rst_int_reg = (state_q == StCheckParityError);
    wr_en_reg   = (state_q == StLoadData) || (state_q == StLoadParity) ||
                  (state_q == StLoadAfterFull);
    busy        = !((state_q == StDecodeAddress) || (state_q == StLoadData));
    timeout_err = timeout_err_q;
  end

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: directed packet scenarios followed by random traffic, each
// cycle's expected outputs come from a phase-level model of the packet protocol.
module tb_router_fsm;

`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif
  localparam int WaitLimit = 8;

  logic       clk;
  logic       rst;
  logic       pkt_valid;
  logic [1:0] d_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       sft_rst_0, sft_rst_1, sft_rst_2;
  logic       detect_addr, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, wr_en_reg, busy, timeout_err;

  router_fsm #(
    .WAIT_LIMIT(WaitLimit)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_valid     (pkt_valid),
    .d_in          (d_in),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .sft_rst_0     (sft_rst_0),
    .sft_rst_1     (sft_rst_1),
    .sft_rst_2     (sft_rst_2),
    .detect_addr   (detect_addr),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .wr_en_reg     (wr_en_reg),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: packet phase by name, served port, cycles spent in the current wait.
  string       m_phase = "DECODE";
  logic  [1:0] m_addr  = 2'd0;
  int          m_waited = 0;
  bit          m_tmo   = 1'b0;

  logic [8:0] exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         cycle = 0;
  logic [8:0] mon_exp, mon_act;

  // Expected {detect,lfd,ld,laf,full,rst_int,wr_en,busy,timeout} for a phase.
  function automatic logic [8:0] expect_vec(input string ph, input bit tmo);
    bit loading;
    bit idle_or_streaming;
    loading           = (ph == "LD") || (ph == "PARITY") || (ph == "LAF");
    idle_or_streaming = (ph == "DECODE") || (ph == "LD");
    return {ph == "DECODE", ph == "LFD", ph == "LD", ph == "LAF", ph == "FULL",
            ph == "CHECK", loading, !idle_or_streaming, tmo};
  endfunction

  // Drive one cycle of inputs, advance the model and queue the outputs expected after the edge.
  task automatic step(input bit r, input bit pv, input logic [1:0] d, input bit pd,
                      input bit lpv, input bit ff, input logic [2:0] emp, input logic [2:0] sft);
    string nxt;
    bit    tmo;
    @(negedge clk);
    rst = r; pkt_valid = pv; d_in = d; parity_done = pd; low_pkt_valid = lpv; fifo_full = ff;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = emp;
    {sft_rst_2, sft_rst_1, sft_rst_0} = sft;
    tmo = 1'b0;
    nxt = m_phase;
    if (r) begin
      nxt = "DECODE"; m_addr = 2'd0; m_waited = 0;
    end else begin
      if (m_phase != "DECODE" && sft[m_addr]) nxt = "DECODE";
      else if (TmoEn && (m_phase == "WAIT" || m_phase == "FULL") && m_waited == WaitLimit) begin
        nxt = "DECODE"; tmo = 1'b1;
      end else if (m_phase == "DECODE") begin
        if (pv && d != 2'd3) nxt = emp[d] ? "LFD" : "WAIT";
      end else if (m_phase == "LFD") nxt = "LD";
      else if (m_phase == "LD") begin
        if (ff) nxt = "FULL";
        else if (!pv) nxt = "PARITY";
      end else if (m_phase == "FULL") begin
        if (!ff) nxt = "LAF";
      end else if (m_phase == "LAF") begin
        nxt = pd ? "DECODE" : (lpv ? "PARITY" : "LD");
      end else if (m_phase == "PARITY") nxt = "CHECK";
      else if (m_phase == "CHECK") nxt = ff ? "FULL" : "DECODE";
      else if (m_phase == "WAIT") begin
        if (emp[m_addr]) nxt = "LFD";
      end
      if (m_phase == "DECODE" && pv && d != 2'd3) m_addr = d;
      if (nxt == "WAIT" || nxt == "FULL") m_waited = (nxt == m_phase) ? m_waited + 1 : 1;
      else m_waited = 0;
    end
    m_phase = nxt;
    m_tmo   = tmo;
    exp_q.push_back(expect_vec(m_phase, m_tmo));
  endtask

  // Monitor: every cycle the DUT presents its Moore outputs; compare against the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                   wr_en_reg, busy, timeout_err};
        tests++;
        if (mon_act !== mon_exp) begin
          fails++;
          $display("FAIL outputs cycle %0d phase %s: got %b expected %b", cycle, m_phase,
                   mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; pkt_valid = 1'b0; d_in = 2'd0; parity_done = 1'b0; low_pkt_valid = 1'b0;
    fifo_full = 1'b0; {fifo_empty_2, fifo_empty_1, fifo_empty_0} = 3'b000;
    {sft_rst_2, sft_rst_1, sft_rst_0} = 3'b000;

    // Reset.
    step(1, 0, 2'd0, 0, 0, 0, 3'b000, 3'b000);
    // Port 1 packet straight through to parity check.
    step(0, 1, 2'd1, 0, 0, 0, 3'b010, 3'b000);
    step(0, 1, 2'd1, 0, 0, 0, 3'b010, 3'b000);
    step(0, 1, 2'd1, 0, 0, 0, 3'b010, 3'b000);
    step(0, 0, 2'd1, 0, 0, 0, 3'b010, 3'b000);
    step(0, 0, 2'd1, 0, 0, 0, 3'b010, 3'b000);
    step(0, 0, 2'd1, 0, 0, 0, 3'b010, 3'b000);
    // Port 2 busy: wait, then it drains.
    step(0, 1, 2'd2, 0, 0, 0, 3'b000, 3'b000);
    repeat (5) step(0, 0, 2'd2, 0, 0, 0, 3'b000, 3'b000);
    step(0, 0, 2'd2, 0, 0, 0, 3'b100, 3'b000);
    // Back-pressure while loading, resume, early parity, then invalid address dropped.
    step(0, 1, 2'd2, 0, 0, 0, 3'b100, 3'b000);
    step(0, 1, 2'd2, 0, 0, 1, 3'b100, 3'b000);
    step(0, 1, 2'd2, 0, 0, 1, 3'b100, 3'b000);
    step(0, 1, 2'd2, 0, 0, 0, 3'b100, 3'b000);
    step(0, 0, 2'd2, 0, 1, 0, 3'b100, 3'b000);
    step(0, 0, 2'd2, 0, 0, 0, 3'b100, 3'b000);
    step(0, 0, 2'd2, 0, 0, 0, 3'b100, 3'b000);
    step(0, 1, 2'd3, 0, 0, 0, 3'b111, 3'b000);
    step(0, 1, 2'd3, 0, 0, 0, 3'b111, 3'b000);
    // Port 0 loading: foreign soft reset ignored, own soft reset aborts.
    step(0, 1, 2'd0, 0, 0, 0, 3'b001, 3'b000);
    step(0, 1, 2'd0, 0, 0, 0, 3'b001, 3'b000);
    step(0, 1, 2'd0, 0, 0, 0, 3'b001, 3'b010);
    step(0, 1, 2'd0, 0, 0, 0, 3'b001, 3'b001);
    // Reset mid-packet.
    step(0, 1, 2'd1, 0, 0, 0, 3'b010, 3'b000);
    step(0, 1, 2'd1, 0, 0, 0, 3'b010, 3'b000);
    step(1, 1, 2'd1, 0, 0, 0, 3'b010, 3'b000);
    step(0, 0, 2'd1, 0, 0, 0, 3'b010, 3'b000);
    // Port 0 never drains: abort with the timeout feature, indefinite wait without it.
    step(0, 1, 2'd0, 0, 0, 0, 3'b000, 3'b000);
    repeat (12) step(0, 0, 2'd0, 0, 0, 0, 3'b000, 3'b000);
    // Stuck full after parity check.
    step(0, 1, 2'd1, 0, 0, 0, 3'b010, 3'b000);
    step(0, 1, 2'd1, 0, 0, 0, 3'b010, 3'b000);
    step(0, 0, 2'd1, 0, 0, 0, 3'b010, 3'b000);
    step(0, 0, 2'd1, 0, 0, 0, 3'b010, 3'b000);
    repeat (12) step(0, 0, 2'd1, 0, 0, 1, 3'b010, 3'b000);
    step(1, 0, 2'd0, 0, 0, 0, 3'b000, 3'b000);

    // Random traffic.
    repeat (4000) begin
      step(($urandom % 60) == 0, ($urandom % 10) < 7, 2'($urandom % 4), ($urandom % 8) == 0,
           ($urandom % 6) == 0, ($urandom % 5) == 0,
           {($urandom % 5) < 2, ($urandom % 5) < 2, ($urandom % 5) < 2},
           {($urandom % 25) == 0, ($urandom % 25) == 0, ($urandom % 25) == 0});
    end

    @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
